rom_port_arbiter: RTL and testbench
===================================

Name: rom_port_arbiter

Overview:
- Shares one combinational, single-ported 256x32 ROM read port between two requesters, e.g. instruction fetch (port 0) and a debug/data reader (port 1).
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration; registered response one cycle after acceptance.
- Sits between the requesters and the ROM instance in the top-level glue.

Parameters:
- ADDR_W, 8, ROM word-address width.
- DATA_W, 32, ROM word width.
- CNT_W, 16, perf counter width (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  port 0 request valid.
- req0_addr  in  ADDR_W  port 0 word address.
- req0_ready  out  1  port 0 request accepted this cycle.
- resp0_valid  out  1  port 0 response valid.
- resp0_data  out  DATA_W  port 0 response data.
- resp0_ready  in  1  port 0 consumer takes the response.
- req1_valid / req1_addr / req1_ready / resp1_valid / resp1_data / resp1_ready: same as port 0, for port 1.
- rom_addr  out  ADDR_W  address driven to the ROM.
- rom_data  in  DATA_W  ROM read data, combinational from rom_addr.

Behaviour:
- Per-port state: resp_valid_i (1 bit), resp_data_i (DATA_W); shared state: prio (1 bit, index of the preferred port).
- Reset (async, immediate):
  - resp_valid_i = 0, resp_data_i = 0.
  - prio = 0, so port 0 is preferred after reset.
  - Outputs settle to their combinational values from this cleared state.
- slot_free_i = !resp_valid_i || resp_ready_i.
- eligible_i = req_valid_i && slot_free_i.
- Grant (combinational):
  - Both eligible: grant port prio.
  - One eligible: grant that port.
  - Neither eligible: no grant.
  - At most one grant per cycle.
- reqi_ready = grant_i. Ready may depend on valid; requesters must not make valid depend on ready.
- rom_addr = req1_addr when port 1 is granted, otherwise req0_addr (port 0 address when idle).
- On a clock edge with grant_i: resp_valid_i <= 1, resp_data_i <= rom_data.
- On a clock edge without grant_i but with resp_ready_i: resp_valid_i <= 0, resp_data_i holds.
- Drain and accept in the same cycle on one port is allowed; the new response replaces the drained one. This gives back-to-back streaming at 1 word/cycle.
- prio update on every grant: prio <= the index of the port not granted. Unchanged when there is no grant.
- Latency: response is valid on the cycle after acceptance.
- Response data is stable while resp_valid_i = 1 and resp_ready_i = 0.
- Backpressure: a full, undrained port is not eligible. The other port may take every cycle.
- Request fields may change freely while not accepted; there is no request buffering.
- Aggregate throughput is one access per cycle.
- Addresses are used as is; ADDR_W bits cover the full ROM, so there is no wrap or range check.

Optional Feature:
- Macro: ROM_ARB_PERF_EN.
- Defined: adds outputs perf_grants0, perf_grants1 and perf_conflicts, each CNT_W bits.
  - perf_grants0 / perf_grants1 increment on each accept on that port.
  - perf_conflicts increments on each cycle where both ports are eligible.
  - All counters wrap modulo 2^CNT_W and reset to 0.
- Undefined: the ports and counters are absent; arbitration behaviour is identical.

Test Plan:
- Reset asserted mid-run with resp0_valid=1 -> resp0_valid and resp1_valid drop without waiting for a clock edge; after release, the first contention grants port 0.
- ROM[0x05]=0xDEADBEEF; port 0 requests 0x05, port 1 idle -> req0_ready=1 the same cycle; resp0_valid=1 with resp0_data=0xDEADBEEF the next cycle, and rom_addr=0x05 during the request.
- Both ports valid every cycle, both resp_ready=1, addresses 0x10 / 0x20 -> grant order 0,1,0,1; each resp_valid pulses on alternate cycles with ROM[0x10] / ROM[0x20] respectively.
- Port 0 gets a response, then holds resp0_ready=0 for 5 cycles with req0_valid=1 while port 1 streams -> req0_ready=0 and resp0_data stable throughout; port 1 is accepted every cycle; on the cycle resp0_ready rises, port 0 is accepted again when prio allows.
- Port 1 alone streams addresses 0..7 with resp1_ready=1 -> 8 accepts in 8 consecutive cycles and resp1_data = ROM[0..7] in order, one cycle behind each accept.
- With ROM_ARB_PERF_EN defined, run the contention scenario above for 10 cycles -> perf_conflicts=10, perf_grants0=5, perf_grants1=5.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// Two-port round-robin arbiter in front of a combinational single-ported ROM.
// Optional perf counters are enabled by defining ROM_ARB_PERF_EN.

module rom_arb_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              grant,
  input  logic              resp_ready,
  input  logic [DATA_W-1:0] rom_data,
  output logic              slot_free,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data
);
  // A drained slot can be refilled on the same edge, which gives 1 word/cycle.
  assign slot_free = !resp_valid || resp_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else if (grant) begin
      resp_valid <= 1'b1;
      resp_data  <= rom_data;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end
endmodule

module rom_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_data,
  input  logic              resp0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_data,
  input  logic              resp1_ready,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
`ifdef ROM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_grants0,
  output logic [CNT_W-1:0]  perf_grants1,
  output logic [CNT_W-1:0]  perf_conflicts
`endif
);
  localparam int NUM_PORTS = 2;

  logic [NUM_PORTS-1:0]             req_valid, resp_ready, slot_free, eligible, grant, resp_valid;
  logic [NUM_PORTS-1:0][DATA_W-1:0] resp_data;
  logic                             prio;

  assign req_valid  = {req1_valid, req0_valid};
  assign resp_ready = {resp1_ready, resp0_ready};
  assign eligible   = req_valid & slot_free;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slot
    rom_arb_slot #(.DATA_W(DATA_W)) u_slot (
      .clock      (clock),
      .reset      (reset),
      .grant      (grant[i]),
      .resp_ready (resp_ready[i]),
      .rom_data   (rom_data),
      .slot_free  (slot_free[i]),
      .resp_valid (resp_valid[i]),
      .resp_data  (resp_data[i])
    );
  end

  always_comb begin
    grant = '0;
    if (&eligible) grant[prio] = 1'b1;
    else           grant       = eligible;
  end

  // prio points at whichever port lost (or sat out) the last grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       prio <= 1'b0;
    else if (|grant) prio <= grant[0];
  end

  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];
  assign resp0_valid = resp_valid[0];
  assign resp1_valid = resp_valid[1];
  assign resp0_data  = resp_data[0];
  assign resp1_data  = resp_data[1];
  assign rom_addr    = grant[1] ? req1_addr : req0_addr;

`ifdef ROM_ARB_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_grants0   <= '0;
      perf_grants1   <= '0;
      perf_conflicts <= '0;
    end else begin
      perf_grants0   <= perf_grants0 + CNT_W'(grant[0]);
      perf_grants1   <= perf_grants1 + CNT_W'(grant[1]);
      perf_conflicts <= perf_conflicts + CNT_W'(&eligible);
    end
  end
`endif
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of the arbiter and a ROM image.

module tb_rom_port_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        r0v = 0, r1v = 0, p0r = 0, p1r = 0;
  logic [7:0]  r0a = 0, r1a = 0;
  logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [31:0] resp0_data, resp1_data, rom_data;
  logic [7:0]  rom_addr;
  logic [31:0] rom [256];
`ifdef ROM_ARB_PERF_EN
  logic [15:0] perf_grants0, perf_grants1, perf_conflicts;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [1:0]  m_vld;
  logic [31:0] m_dat0, m_dat1;
  logic        m_pref;
  int          c_g0, c_g1, c_cf;
  logic        x_e0, x_e1, x_g0, x_g1;
  logic [7:0]  x_addr;

  always #5 clock = ~clock;
  assign rom_data = rom[rom_addr];

  rom_port_arbiter dut (
    .clock(clock), .reset(reset),
    .req0_valid(r0v), .req0_addr(r0a), .req0_ready(req0_ready),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data), .resp0_ready(p0r),
    .req1_valid(r1v), .req1_addr(r1a), .req1_ready(req1_ready),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data), .resp1_ready(p1r),
    .rom_addr(rom_addr), .rom_data(rom_data)
`ifdef ROM_ARB_PERF_EN
    , .perf_grants0(perf_grants0), .perf_grants1(perf_grants1), .perf_conflicts(perf_conflicts)
`endif
  );

  // Who should win this cycle, straight from the round-robin rules.
  always_comb begin
    x_e0 = r0v && (!m_vld[0] || p0r);
    x_e1 = r1v && (!m_vld[1] || p1r);
    if (x_e0 && x_e1) begin
      x_g0 = (m_pref == 1'b0);
      x_g1 = (m_pref == 1'b1);
    end else begin
      x_g0 = x_e0;
      x_g1 = x_e1;
    end
    x_addr = x_g1 ? r1a : r0a;
  end

  task automatic model_clear();
    m_vld = 2'b00; m_dat0 = '0; m_dat1 = '0; m_pref = 1'b0;
    c_g0 = 0; c_g1 = 0; c_cf = 0;
  endtask

  task automatic tick();
    logic g0, g1, both, k0, k1;
    logic [7:0] a0, a1;
    g0 = x_g0; g1 = x_g1; both = x_e0 && x_e1;
    a0 = r0a; a1 = r1a; k0 = p0r; k1 = p1r;
    @(posedge clock);
    if (g0) begin m_vld[0] = 1'b1; m_dat0 = rom[a0]; c_g0++; end
    else if (k0) m_vld[0] = 1'b0;
    if (g1) begin m_vld[1] = 1'b1; m_dat1 = rom[a1]; c_g1++; end
    else if (k1) m_vld[1] = 1'b0;
    if (g0) m_pref = 1'b1;
    else if (g1) m_pref = 1'b0;
    if (both) c_cf++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    r0a = 8'h33;
    #3;
    n_cmp++; if ({resp1_valid, resp0_valid} !== 2'b00) begin n_bad++; $display("FAIL reset_valid got %b want 00", {resp1_valid, resp0_valid}); end
    n_cmp++; if (resp0_data !== 32'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", resp0_data); end
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready got %b want 00", {req1_ready, req0_ready}); end
    n_cmp++; if (rom_addr !== 8'h33) begin n_bad++; $display("FAIL idle_rom_addr got %h want 33", rom_addr); end
    reset = 1'b0;
    tick();
    r0v = 1; r0a = 8'h44; p0r = 0;
    #1; tick();
    r0v = 0;
    #1;
    n_cmp++; if (resp0_valid !== 1'b1) begin n_bad++; $display("FAIL pre_reset_valid got %b want 1", resp0_valid); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({resp1_valid, resp0_valid} !== 2'b00) begin n_bad++; $display("FAIL async_reset got %b want 00", {resp1_valid, resp0_valid}); end
    model_clear();
    reset = 1'b0;
    r0v = 1; r1v = 1; r0a = 8'h01; r1a = 8'h02; p0r = 1; p1r = 1;
    #1;
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_bad++; $display("FAIL post_reset_prio got %b want 01", {req1_ready, req0_ready}); end
    tick();
  endtask

  task automatic test_single();
    r0v = 1; r0a = 8'h05; r1v = 0; p0r = 1; p1r = 1;
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready got %b want 1", req0_ready); end
    n_cmp++; if (rom_addr !== 8'h05) begin n_bad++; $display("FAIL single_rom_addr got %h want 05", rom_addr); end
    tick();
    r0v = 0;
    #1;
    n_cmp++; if (resp0_valid !== 1'b1) begin n_bad++; $display("FAIL single_resp_valid got %b want 1", resp0_valid); end
    n_cmp++; if (resp0_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_resp_data got %h want deadbeef", resp0_data); end
  endtask

  task automatic test_contention();
    do_reset();
    r0v = 1; r1v = 1; r0a = 8'h10; r1a = 8'h20; p0r = 1; p1r = 1;
    for (int k = 0; k < 10; k++) begin
      #1;
      n_cmp++;
      if ({req1_ready, req0_ready} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_bad++; $display("FAIL contention_grant cyc %0d got %b", k, {req1_ready, req0_ready});
      end
      tick();
      n_cmp++;
      if ({resp1_valid, resp0_valid} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_bad++; $display("FAIL contention_resp_valid cyc %0d got %b", k, {resp1_valid, resp0_valid});
      end
      n_cmp++;
      if ((k % 2 == 0) ? (resp0_data !== rom[8'h10]) : (resp1_data !== rom[8'h20])) begin
        n_bad++; $display("FAIL contention_data cyc %0d got %h / %h want %h / %h", k, resp0_data, resp1_data, rom[8'h10], rom[8'h20]);
      end
    end
`ifdef ROM_ARB_PERF_EN
    n_cmp++; if (perf_conflicts !== 16'd10) begin n_bad++; $display("FAIL perf_conflicts got %0d want 10", perf_conflicts); end
    n_cmp++; if (perf_grants0 !== 16'd5) begin n_bad++; $display("FAIL perf_grants0 got %0d want 5", perf_grants0); end
    n_cmp++; if (perf_grants1 !== 16'd5) begin n_bad++; $display("FAIL perf_grants1 got %0d want 5", perf_grants1); end
`endif
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    do_reset();
    r0v = 1; r0a = 8'h40; r1v = 0; p0r = 1; p1r = 1;
    #1; tick();
    held = rom[8'h40];
    p0r = 0; r0a = 8'h41; r1v = 1;
    for (int k = 0; k < 5; k++) begin
      r1a = 8'(8'h50 + k);
      #1;
      n_cmp++;
      if ({req1_ready, req0_ready} !== 2'b10) begin n_bad++; $display("FAIL bp_ready cyc %0d got %b want 10", k, {req1_ready, req0_ready}); end
      tick();
      n_cmp++;
      if (resp0_valid !== 1'b1 || resp0_data !== held) begin
        n_bad++; $display("FAIL bp_hold cyc %0d got %b/%h want 1/%h", k, resp0_valid, resp0_data, held);
      end
      n_cmp++;
      if (resp1_data !== rom[8'h50 + k]) begin n_bad++; $display("FAIL bp_stream cyc %0d got %h want %h", k, resp1_data, rom[8'h50 + k]); end
    end
    p0r = 1; r1a = 8'h60;
    #1;
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_bad++; $display("FAIL bp_release got %b want 01", {req1_ready, req0_ready}); end
    tick();
    n_cmp++; if (resp0_data !== rom[8'h41]) begin n_bad++; $display("FAIL bp_release_data got %h want %h", resp0_data, rom[8'h41]); end
  endtask

  task automatic test_stream();
    do_reset();
    r0v = 0; r1v = 1; p0r = 1; p1r = 1;
    for (int k = 0; k < 8; k++) begin
      r1a = 8'(k);
      #1;
      n_cmp++; if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL stream_ready cyc %0d got %b want 1", k, req1_ready); end
      tick();
      n_cmp++;
      if (resp1_valid !== 1'b1 || resp1_data !== rom[k]) begin
        n_bad++; $display("FAIL stream_data cyc %0d got %b/%h want 1/%h", k, resp1_valid, resp1_data, rom[k]);
      end
    end
    r1v = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      r0v = ($urandom_range(9) < 7); r1v = ($urandom_range(9) < 7);
      p0r = ($urandom_range(9) < 6); p1r = ($urandom_range(9) < 6);
      r0a = 8'($urandom); r1a = 8'($urandom);
      #1;
      n_cmp++;
      if ({req1_ready, req0_ready} !== {x_g1, x_g0}) begin n_bad++; $display("FAIL rand_grant cyc %0d got %b want %b", k, {req1_ready, req0_ready}, {x_g1, x_g0}); end
      n_cmp++;
      if (rom_addr !== x_addr) begin n_bad++; $display("FAIL rand_rom_addr cyc %0d got %h want %h", k, rom_addr, x_addr); end
      tick();
      n_cmp++;
      if ({resp1_valid, resp0_valid} !== m_vld) begin n_bad++; $display("FAIL rand_resp_valid cyc %0d got %b want %b", k, {resp1_valid, resp0_valid}, m_vld); end
      n_cmp++;
      if (resp0_data !== m_dat0) begin n_bad++; $display("FAIL rand_resp0_data cyc %0d got %h want %h", k, resp0_data, m_dat0); end
      n_cmp++;
      if (resp1_data !== m_dat1) begin n_bad++; $display("FAIL rand_resp1_data cyc %0d got %h want %h", k, resp1_data, m_dat1); end
    end
`ifdef ROM_ARB_PERF_EN
    n_cmp++;
    if ({perf_grants0, perf_grants1, perf_conflicts} !== {c_g0[15:0], c_g1[15:0], c_cf[15:0]}) begin
      n_bad++; $display("FAIL rand_perf got %0d/%0d/%0d want %0d/%0d/%0d", perf_grants0, perf_grants1, perf_conflicts, c_g0, c_g1, c_cf);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[8'h05] = 32'hDEADBEEF;
    model_clear();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_stream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
